alu_mp_sequencer: RTL and testbench
===================================

// Module: alu_mp_sequencer
// PURPOSE
//   Multi-precision front end for the 8-bit combinational ALU. Accepts one wide command
//   (fn, A, B, cin) over a valid/ready handshake and feeds the ALU one byte per cycle, LSB first.
//   Chains carry/borrow between bytes and assembles the full-width result with aggregate
//   carry and zero flags. Sits directly upstream of the ALU and drives all of its inputs.
// PARAMETERS
//   NBYTES  4  operand width in bytes (legal range 1..16); data width W = 8*NBYTES
// PORTS
//   clk        in   1   clock; all state updates on the rising edge
//   rst_n      in   1   reset; asynchronous assert, active low
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   sequencer can accept a command (IDLE only)
//   cmd_fn     in   3   ALU function: 00x add, 01x sub, 100 AND, 101 OR, 110 XOR, 111 NAND
//   cmd_a      in   W   operand A
//   cmd_b      in   W   operand B
//   cmd_cin    in   1   carry-in (add) or borrow-in (sub) for byte 0; ignored for logic ops
//   alu_fn     out  3   to ALU fn
//   alu_a      out  8   to ALU op_A (current byte of A)
//   alu_b      out  8   to ALU op_B (current byte of B)
//   alu_cin    out  1   to ALU cin
//   alu_out    in   8   from ALU out
//   alu_co     in   1   from ALU co (carry for add, borrow for sub)
//   alu_z      in   1   from ALU z (unused internally; aggregate z is computed from res_data)
//   res_valid  out  1   result available
//   res_ready  in   1   consumer accepts result
//   res_data   out  W   full-width result
//   res_co     out  1   final carry/borrow out of MSB byte; 0 for logic ops
//   res_z      out  1   1 when res_data == 0
// BEHAVIOUR
//   - FSM states: IDLE, EXEC, DONE. Byte index idx, width $clog2(NBYTES) (min 1 bit).
//   - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, cmd_ready=1 (combinational from IDLE),
//     res_valid=0, res_data=0, res_co=0, res_z=0. Latched fn/A/B cleared to 0.
//   - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch fn/A/B; carry <= cmd_cin if fn[2]==0,
//     else 0; clear res_data, idx=0; go EXEC.
//   - EXEC: cmd_ready=0. alu_fn=fn, alu_a=A[8*idx+:8], alu_b=B[8*idx+:8], alu_cin=carry
//     (combinational). At each edge: res_data[8*idx+:8] <= alu_out; carry <= alu_co.
//     When idx==NBYTES-1: res_co <= alu_co, res_z <= (assembled result == 0), res_valid <= 1,
//     go DONE. Otherwise idx <= idx+1.
//   - Sub chaining: ALU computes A-B-cin per byte; co=1 means borrow, fed to the next byte as cin.
//   - Latency: command accepted at edge k -> res_valid=1 after edge k+NBYTES.
//     NBYTES=1 -> single EXEC cycle.
//   - DONE: res_valid=1; res_data/res_co/res_z held stable while res_ready=0.
//     On res_ready: res_valid <= 0, go IDLE. cmd_ready stays 0 in DONE
//     (no overlap; throughput 1 cmd per NBYTES+2 cycles minimum).
//   - ALU drive outside EXEC: alu_fn=latched fn, alu_a=0, alu_b=0, alu_cin=0.
//   - cmd_* changes while cmd_ready=0 are ignored. cmd_valid may drop without acceptance.
//   - Reset mid-EXEC or mid-DONE: command aborted, partial result discarded, res_valid=0 immediately.
//   - Arithmetic wrap: result is modulo 2^W; overflow is reported only via res_co.
// TESTING (NBYTES=4)
//   1. add A=0x000000FF B=0x00000001 cin=0 -> res_valid 4 cycles after accept,
//      res_data=0x00000100, co=0, z=0
//   2. add A=0xFFFFFFFF B=0x00000000 cin=1 -> res_data=0x00000000, co=1, z=1
//      (carry ripples through all bytes)
//   3. sub A=0x00000100 B=0x00000001 cin=0 -> 0x000000FF, co=0;
//      sub A=5 B=6 cin=0 -> 0xFFFFFFFF, co=1, z=0
//   4. NAND A=0xFFFF0000 B=0xFF00FF00 cin=1 -> 0x00FFFFFF, co=0 (cin ignored for logic ops)
//   5. backpressure: res_ready=0 for 10 cycles -> res_valid/res_data held, cmd_ready=0;
//      cmd_valid toggled meanwhile is not accepted
//   6. rst_n low during EXEC at idx=2 -> all outputs at reset values immediately;
//      next command then completes correctly

Source files
------------

// File: rtl/alu_mp_sequencer.sv
// ============================================================================
//  Module   : alu_mp_sequencer
//  Purpose  : Multi-precision front end that streams a wide command through an
//             8-bit ALU one byte per cycle, LSB first, chaining carry/borrow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mp_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_fn,
   input  logic [8*NBYTES-1:0]   cmd_a,
   input  logic [8*NBYTES-1:0]   cmd_b,
   input  logic                  cmd_cin,
   output logic [2:0]            alu_fn,
   output logic [7:0]            alu_a,
   output logic [7:0]            alu_b,
   output logic                  alu_cin,
   input  logic [7:0]            alu_out,
   input  logic                  alu_co,
   input  logic                  alu_z,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [8*NBYTES-1:0]   res_data,
   output logic                  res_co,
   output logic                  res_z
);

   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] c_LAST = IDXW'(NBYTES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                r_state;
   logic [1:0]                w_state_nxt;
   logic [IDXW-1:0]           r_idx;
   logic                      r_carry;
   logic [2:0]                r_fn;
   logic [NBYTES-1:0][7:0]    r_a;
   logic [NBYTES-1:0][7:0]    r_b;
   logic [NBYTES-1:0][7:0]    r_res;
   logic [NBYTES-1:0][7:0]    w_res_nxt;
   logic                      r_res_co;
   logic                      r_res_z;
   logic                      r_res_valid;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_unused_alu_z;

   assign w_unused_alu_z = alu_z;
   assign w_accept       = cmd_valid && (r_state == S_IDLE);
   assign w_last         = (r_idx == c_LAST);

   assign res_valid = r_res_valid;
   assign res_data  = r_res;
   assign res_co    = r_res_co;
   assign res_z     = r_res_z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
         S_EXEC:  if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (r_state == S_IDLE);
      alu_fn    = r_fn;
      alu_a     = 8'h00;
      alu_b     = 8'h00;
      alu_cin   = 1'b0;
      if (r_state == S_EXEC) begin
         alu_a   = r_a[r_idx];
         alu_b   = r_b[r_idx];
         alu_cin = r_carry;
      end
   end

   // Result as it will look after this edge; the zero flag needs the final byte included.
   always_comb begin
      w_res_nxt        = r_res;
      w_res_nxt[r_idx] = alu_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_fn        <= 3'b000;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_res_co    <= 1'b0;
         r_res_z     <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_fn    <= cmd_fn;
                  r_a     <= cmd_a;
                  r_b     <= cmd_b;
                  r_carry <= cmd_cin & ~cmd_fn[2];
                  r_res   <= '0;
                  r_idx   <= '0;
               end
            end
            S_EXEC: begin
               r_res   <= w_res_nxt;
               r_carry <= alu_co;
               if (w_last) begin
                  r_res_co    <= alu_co & ~r_fn[2];
                  r_res_z     <= (w_res_nxt == '0);
                  r_res_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) r_res_valid <= 1'b0;
            end
            default: r_res_valid <= 1'b0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_mp_sequencer.sv
// ============================================================================
//  Module   : tb_alu_mp_sequencer
//  Purpose  : Scoreboard bench for alu_mp_sequencer with a byte-wide ALU model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_mp_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_fn;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic          cmd_cin;
   logic [2:0]    alu_fn;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic          alu_cin;
   logic [7:0]    alu_out;
   logic          alu_co;
   logic          alu_z;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic          res_co;
   logic          res_z;

   typedef struct {
      logic [W-1:0] data;
      logic         co;
      logic         z;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   bit   mon_prev = 1'b0;
   bit   rr_rand  = 1'b0;

   alu_mp_sequencer #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_fn    (cmd_fn),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_cin   (cmd_cin),
      .alu_fn    (alu_fn),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_cin   (alu_cin),
      .alu_out   (alu_out),
      .alu_co    (alu_co),
      .alu_z     (alu_z),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_co    (res_co),
      .res_z     (res_z)
   );

   // 8-bit combinational ALU the sequencer drives
   always_comb begin
      logic [8:0] t;
      t = 9'h000;
      case (alu_fn)
         3'b000, 3'b001: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
         3'b010, 3'b011: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
         3'b100:         t = {1'b0, alu_a & alu_b};
         3'b101:         t = {1'b0, alu_a | alu_b};
         3'b110:         t = {1'b0, alu_a ^ alu_b};
         default:        t = {1'b0, ~(alu_a & alu_b)};
      endcase
      alu_out = t[7:0];
      alu_co  = t[8];
      alu_z   = (t[7:0] == 8'h00);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rr_rand) begin
         #2;
         if (rr_rand) res_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] fn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin);
      exp_t       e;
      logic [W:0] t;
      case (fn[2:1])
         2'b00:   t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         2'b01:   t = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
         default: begin
            case (fn[1:0])
               2'b00:   t = {1'b0, a & b};
               2'b01:   t = {1'b0, a | b};
               2'b10:   t = {1'b0, a ^ b};
               default: t = {1'b0, ~(a & b)};
            endcase
         end
      endcase
      e.data = t[W-1:0];
      e.co   = t[W];
      e.z    = (t[W-1:0] == '0);
      e.acc  = 0;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
      exp_t e;
      int   n = 0;
      cmd_fn    = fn;
      cmd_a     = a;
      cmd_b     = b;
      cmd_cin   = cin;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 64'(cmd_ready), 64'd1);
      end else begin
         e     = model(fn, a, b, cin);
         e.acc = cyc + 1;
         q.push_back(e);
      end
      tick();
      cmd_valid = 1'b0;
      cmd_fn    = 3'($urandom);
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      cmd_cin   = 1'($urandom);
   endtask

   // Monitor: latency on the rising result, then pop and compare on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (res_valid && !mon_prev) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got res_valid=1 with data %h expected no pending command", res_data);
            end else begin
               check("latency", 64'(cyc - q[0].acc), 64'(NBYTES));
            end
         end
         if (res_valid && res_ready && q.size() != 0) begin
            e = q.pop_front();
            check("res_data", 64'(res_data), 64'(e.data));
            check("res_co",   64'(res_co),   64'(e.co));
            check("res_z",    64'(res_z),    64'(e.z));
         end
      end
      mon_prev = res_valid && rst_n;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_res_data"},  64'(res_data),  64'd0);
      check({tag, "_res_co"},    64'(res_co),    64'd0);
      check({tag, "_res_z"},     64'(res_z),     64'd0);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_alu_fn"},    64'(alu_fn),    64'd0);
      check({tag, "_alu_a"},     64'(alu_a),     64'd0);
      check({tag, "_alu_cin"},   64'(alu_cin),   64'd0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      check({tag, "_drain_pending"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_fn    = 3'b000;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_cin   = 1'b0;
      res_ready = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      send(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      send(3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      send(3'b010, 32'h0000_0100, 32'h0000_0001, 1'b0);
      send(3'b011, 32'h0000_0005, 32'h0000_0006, 1'b0);
      send(3'b111, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1);
      send(3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
      send(3'b101, 32'h0000_0000, 32'h0000_0000, 1'b1);
      send(3'b110, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
      drain("directed");

      // Backpressure: result must hold while res_ready is low and no command is taken.
      res_ready = 1'b0;
      send(3'b010, 32'h1234_5678, 32'h2345_6789, 1'b1);
      begin
         int n = 0;
         while (!res_valid && n < 50) begin
            tick();
            n++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i % 2 == 0);
         cmd_fn    = 3'($urandom);
         cmd_a     = W'($urandom);
         cmd_b     = W'($urandom);
         tick();
         check("bp_res_valid", 64'(res_valid), 64'd1);
         check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
         if (q.size() != 0) check("bp_res_data", 64'(res_data), 64'(q[0].data));
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      drain("backpressure");
      repeat (NBYTES + 3) tick();

      // Reset while byte 2 is executing aborts the command.
      send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      void'(q.pop_back());
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send(3'b000, 32'h1234_5678, 32'h1111_1111, 1'b1);
      drain("after_abort");

      rr_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 3))
            0:       a = '1;
            1:       b = a;
            default: ;
         endcase
         send(3'($urandom), a, b, 1'($urandom));
      end
      rr_rand = 1'b0;
      res_ready = 1'b1;
      drain("random");
      repeat (NBYTES + 3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
